// File: rtl/pe_buffer_replay_ctrl_if.sv
// Handshake and buffer-control bundle between the replay controller and its
// surroundings (config source, upstream writer, PE lane, PE buffer).
interface pe_buffer_replay_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  CFG_VALID;
  logic                  CFG_READY;
  logic [ADDR_WIDTH:0]   CFG_TILE_LEN;
  logic [CNT_WIDTH-1:0]  CFG_REPEAT;
  logic [CNT_WIDTH-1:0]  CFG_NUM_TILES;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic                  OUT_READY;
  logic                  OUT_VALID;
  logic                  OUT_LAST_WORD;
  logic                  OUT_LAST_PASS;
  logic                  BUF_PUSH;
  logic                  BUF_POP;
  logic                  BUF_SAVE;
  logic                  BUF_RESTORE;
  logic                  BUF_EMPTY;
  logic                  BUF_FULL;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;

  // Environment side: config source, upstream writer, PE lane, buffer flags.
  modport master (
    output CFG_VALID, CFG_TILE_LEN, CFG_REPEAT, CFG_NUM_TILES,
    output IN_VALID, OUT_READY, BUF_EMPTY, BUF_FULL,
    input  CFG_READY, IN_READY, OUT_VALID, OUT_LAST_WORD, OUT_LAST_PASS,
    input  BUF_PUSH, BUF_POP, BUF_SAVE, BUF_RESTORE, BUSY, DONE, ERR
  );

  // Controller side.
  modport slave (
    input  CFG_VALID, CFG_TILE_LEN, CFG_REPEAT, CFG_NUM_TILES,
    input  IN_VALID, OUT_READY, BUF_EMPTY, BUF_FULL,
    output CFG_READY, IN_READY, OUT_VALID, OUT_LAST_WORD, OUT_LAST_PASS,
    output BUF_PUSH, BUF_POP, BUF_SAVE, BUF_RESTORE, BUSY, DONE, ERR
  );
endinterface

// File: rtl/pe_buffer_replay_ctrl.sv
// Replay sequencer for one PE buffer: each tile written once by the memory
// stream is read back CFG_REPEAT times via SAVE/RESTORE of the read address,
// while the next tile is written behind the buffer's checkpoint.
module pe_buffer_replay_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  pe_buffer_replay_ctrl_if.slave   bus
);

  localparam logic [ADDR_WIDTH:0]  ONE_W = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]  DEPTH = ONE_W << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_READ,
    ST_RESTORE,
    ST_FINISH
  } state_t;

  state_t               state, state_d;
  logic [ADDR_WIDTH:0]  word_cnt, word_d;
  logic [CNT_WIDTH-1:0] pass_cnt, pass_d;
  logic [CNT_WIDTH-1:0] tile_cnt, tile_d;
  logic [ADDR_WIDTH:0]  cfg_tile_len;
  logic [CNT_WIDTH-1:0] cfg_repeat;
  logic [CNT_WIDTH-1:0] cfg_num_tiles;
  logic [ADDR_WIDTH:0]  wr_words;
  logic [CNT_WIDTH-1:0] wr_tiles;
  logic                 out_valid, out_last_word, out_last_pass;
  logic                 done, err;

  logic                 cfg_accept, cfg_bad, busy;
  logic                 in_ready, push, pop, save, restore;
  logic [ADDR_WIDTH:0]  tile_last;
  logic [CNT_WIDTH-1:0] rep_last, tiles_last;

  assign cfg_accept = bus.CFG_VALID && (state == ST_IDLE);
  assign cfg_bad    = (bus.CFG_TILE_LEN == '0) || (bus.CFG_TILE_LEN > DEPTH) ||
                      (bus.CFG_REPEAT == '0) || (bus.CFG_NUM_TILES == '0);
  assign busy       = (state != ST_IDLE);
  assign tile_last  = cfg_tile_len - ONE_W;
  assign rep_last   = cfg_repeat - ONE_C;
  assign tiles_last = cfg_num_tiles - ONE_C;

  // Write side runs independently of the read FSM; it only pauses during
  // RESTORE so the buffer never sees a push and a read-address rewind together.
  assign in_ready = busy && !bus.BUF_FULL && (state != ST_RESTORE) &&
                    (wr_tiles < cfg_num_tiles);
  assign push     = bus.IN_VALID && in_ready;

  // Read FSM next-state and buffer read controls.
  always_comb begin
    state_d = state;
    word_d  = word_cnt;
    pass_d  = pass_cnt;
    tile_d  = tile_cnt;
    pop     = 1'b0;
    save    = 1'b0;
    restore = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_accept && !cfg_bad) begin
          state_d = ST_SAVE;
          pass_d  = '0;
          tile_d  = '0;
        end
      end
      ST_SAVE: begin
        save    = 1'b1;
        word_d  = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        pop = bus.OUT_READY && !bus.BUF_EMPTY;
        if (pop) begin
          word_d = word_cnt + ONE_W;
          if (word_cnt == tile_last) begin
            word_d = '0;
            if (pass_cnt < rep_last) begin
              state_d = ST_RESTORE;
              pass_d  = pass_cnt + ONE_C;
            end else if (tile_cnt < tiles_last) begin
              state_d = ST_SAVE;
              pass_d  = '0;
              tile_d  = tile_cnt + ONE_C;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end
      end
      ST_RESTORE: begin
        restore = 1'b1;
        word_d  = '0;
        state_d = ST_READ;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FSM state, counters and latched job configuration.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      word_cnt      <= '0;
      pass_cnt      <= '0;
      tile_cnt      <= '0;
      cfg_tile_len  <= '0;
      cfg_repeat    <= '0;
      cfg_num_tiles <= '0;
    end else begin
      state    <= state_d;
      word_cnt <= word_d;
      pass_cnt <= pass_d;
      tile_cnt <= tile_d;
      if (cfg_accept && !cfg_bad) begin
        cfg_tile_len  <= bus.CFG_TILE_LEN;
        cfg_repeat    <= bus.CFG_REPEAT;
        cfg_num_tiles <= bus.CFG_NUM_TILES;
      end
    end
  end

  // Write-side word/tile counters, restarted on every accepted job.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_words <= '0;
      wr_tiles <= '0;
    end else if (cfg_accept && !cfg_bad) begin
      wr_words <= '0;
      wr_tiles <= '0;
    end else if (push) begin
      if (wr_words == tile_last) begin
        wr_words <= '0;
        wr_tiles <= wr_tiles + ONE_C;
      end else begin
        wr_words <= wr_words + ONE_W;
      end
    end
  end

  // Output tags follow the pop by one cycle to line up with buffer DATA_OUT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid     <= 1'b0;
      out_last_word <= 1'b0;
      out_last_pass <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      out_valid     <= pop;
      out_last_word <= pop && (word_cnt == tile_last);
      out_last_pass <= pop && (pass_cnt == rep_last);
      done          <= (state == ST_FINISH);
      err           <= cfg_accept && cfg_bad;
    end
  end

  assign bus.CFG_READY     = (state == ST_IDLE);
  assign bus.IN_READY      = in_ready;
  assign bus.BUF_PUSH      = push;
  assign bus.BUF_POP       = pop;
  assign bus.BUF_SAVE      = save;
  assign bus.BUF_RESTORE   = restore;
  assign bus.OUT_VALID     = out_valid;
  assign bus.OUT_LAST_WORD = out_last_word;
  assign bus.OUT_LAST_PASS = out_last_pass;
  assign bus.BUSY          = busy;
  assign bus.DONE          = done;
  assign bus.ERR           = err;

endmodule

// File: tb/tb_pe_buffer_replay_ctrl.sv
// Bench for pe_buffer_replay_ctrl with a behavioural checkpointing buffer
// (depth 4) and a scoreboard of expected replayed words.
module tb_pe_buffer_replay_ctrl;

  localparam int unsigned AW = 2;
  localparam int unsigned CW = 8;
  localparam logic [AW:0] DEPTH_T = (AW+1)'(1 << AW);

  typedef struct packed {
    logic [7:0] d;
    logic       lw;
    logic       lp;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  pe_buffer_replay_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bi ();

  pe_buffer_replay_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bi.slave)
  );

  // Buffer model: read address can be checkpointed and rewound; fullness is
  // measured from the checkpoint so unreplayed words are never overwritten.
  logic [7:0] mem [0:(1<<AW)-1];
  logic [AW:0] wp, rp, sp;
  logic [7:0] dout, din;

  always @(posedge CLK) begin
    if (RESET) begin
      wp <= '0; rp <= '0; sp <= '0; dout <= '0;
    end else begin
      if (bi.BUF_PUSH) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (bi.BUF_POP) begin
        dout <= mem[rp[AW-1:0]];
        rp <= rp + 1'b1;
      end else if (bi.BUF_RESTORE) begin
        rp <= sp;
      end
      if (bi.BUF_SAVE) sp <= rp;
    end
  end
  assign bi.BUF_EMPTY = (wp == rp);
  assign bi.BUF_FULL  = ((wp - sp) == DEPTH_T);

  int unsigned errors = 0;
  int unsigned checks = 0;
  exp_t        exp_q[$];
  logic [7:0]  src_q[$];
  int unsigned src_idx = 0;
  int unsigned or_mode = 0;
  int unsigned cyc = 0;
  int unsigned out_cnt, restore_cnt, done_cnt, full_cyc, push_cnt, pop_cnt;
  int unsigned last_out_cyc, done_cyc;
  int unsigned watch_push = 0;
  int          pops_at_watch;

  // Upstream writer: offers src_q words in order, advancing on each push.
  initial begin
    bi.IN_VALID = 1'b0;
    din = '0;
    forever begin
      @(negedge CLK);
      if (src_idx < src_q.size()) begin
        bi.IN_VALID = 1'b1;
        din = src_q[src_idx];
      end else begin
        bi.IN_VALID = 1'b0;
      end
      #4;
      if (RESET || (bi.CFG_VALID && bi.CFG_READY)) src_idx = 0;
      else if (bi.BUF_PUSH) src_idx++;
    end
  end

  // PE readiness: always ready, or the 1,0,0 repeating pattern.
  initial begin
    int unsigned ph;
    ph = 0;
    bi.OUT_READY = 1'b1;
    forever begin
      @(negedge CLK);
      if (or_mode == 0) begin
        bi.OUT_READY = 1'b1;
      end else begin
        bi.OUT_READY = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  // Scoreboard and per-cycle protocol monitor.
  initial begin
    exp_t e;
    logic viol;
    forever begin
      @(negedge CLK);
      #2;
      cyc++;
      if (RESET || (bi.CFG_VALID && bi.CFG_READY)) begin
        out_cnt = 0; restore_cnt = 0; done_cnt = 0; full_cyc = 0;
        push_cnt = 0; pop_cnt = 0; pops_at_watch = -1;
        last_out_cyc = 0; done_cyc = 0;
      end else begin
        if (bi.OUT_VALID) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got data=%h, expected no word", dout);
          end else begin
            e = exp_q.pop_front();
            if ({dout, bi.OUT_LAST_WORD, bi.OUT_LAST_PASS} !== {e.d, e.lw, e.lp}) begin
              errors++;
              $display("FAIL out_word[%0d]: got data=%h lw=%b lp=%b, expected data=%h lw=%b lp=%b",
                       out_cnt, dout, bi.OUT_LAST_WORD, bi.OUT_LAST_PASS, e.d, e.lw, e.lp);
            end
          end
          out_cnt++;
          last_out_cyc = cyc;
        end
        if (bi.DONE) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (bi.BUF_RESTORE) restore_cnt++;
        if (bi.BUF_FULL && bi.BUSY) full_cyc++;
        if (bi.BUF_PUSH) begin
          if (push_cnt == watch_push) pops_at_watch = int'(pop_cnt);
          push_cnt++;
        end
        if (bi.BUF_POP) pop_cnt++;
        if (bi.BUSY) begin
          checks++;
          viol = (bi.BUF_POP && (bi.BUF_RESTORE || bi.BUF_SAVE)) ||
                 (bi.BUF_PUSH && bi.BUF_RESTORE) ||
                 (bi.BUF_POP && !bi.OUT_READY) ||
                 (bi.BUF_POP && bi.BUF_EMPTY) ||
                 (bi.IN_READY && bi.BUF_FULL);
          if (viol !== 1'b0) begin
            errors++;
            $display("FAIL protocol: pop=%b save=%b restore=%b push=%b out_ready=%b in_ready=%b full=%b empty=%b, required none of the forbidden combinations",
                     bi.BUF_POP, bi.BUF_SAVE, bi.BUF_RESTORE, bi.BUF_PUSH,
                     bi.OUT_READY, bi.IN_READY, bi.BUF_FULL, bi.BUF_EMPTY);
          end
        end
      end
    end
  end

  task automatic send_cfg(input logic [AW:0] tl, input logic [CW-1:0] rep,
                          input logic [CW-1:0] nt);
    @(negedge CLK);
    bi.CFG_TILE_LEN  = tl;
    bi.CFG_REPEAT    = rep;
    bi.CFG_NUM_TILES = nt;
    bi.CFG_VALID     = 1'b1;
    @(negedge CLK);
    bi.CFG_VALID     = 1'b0;
  endtask

  // Source words are base + 16*tile + word; expected stream is every tile
  // replayed rep times in order.
  task automatic load_job(input int unsigned tl, input int unsigned rep,
                          input int unsigned nt, input logic [7:0] base);
    exp_t e;
    src_q.delete();
    exp_q.delete();
    for (int unsigned t = 0; t < nt; t++)
      for (int unsigned w = 0; w < tl; w++)
        src_q.push_back(base + 8'(16 * t + w));
    for (int unsigned t = 0; t < nt; t++)
      for (int unsigned p = 0; p < rep; p++)
        for (int unsigned w = 0; w < tl; w++) begin
          e.d  = base + 8'(16 * t + w);
          e.lw = (w == tl - 1);
          e.lp = (p == rep - 1);
          exp_q.push_back(e);
        end
  endtask

  task automatic wait_done(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned n = 0; n < budget && !ok; n++) begin
      @(negedge CLK);
      #3;
      if (done_cnt != 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({bi.CFG_READY, bi.BUSY, bi.OUT_VALID, bi.DONE, bi.ERR, bi.IN_READY} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_status: got rdy,busy,ov,done,err,inrdy=%b, expected 100000",
               {bi.CFG_READY, bi.BUSY, bi.OUT_VALID, bi.DONE, bi.ERR, bi.IN_READY});
    end
    checks++;
    if ({bi.BUF_PUSH, bi.BUF_POP, bi.BUF_SAVE, bi.BUF_RESTORE,
         bi.OUT_LAST_WORD, bi.OUT_LAST_PASS} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_buf: got push,pop,save,restore,lw,lp=%b, expected 000000",
               {bi.BUF_PUSH, bi.BUF_POP, bi.BUF_SAVE, bi.BUF_RESTORE,
                bi.OUT_LAST_WORD, bi.OUT_LAST_PASS});
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({bi.CFG_READY, bi.BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL reset_idle: got rdy,busy=%b, expected 10", {bi.CFG_READY, bi.BUSY});
    end
  endtask

  task automatic test_repeat;
    bit ok;
    load_job(4, 3, 1, 8'hA0);
    send_cfg(3'd4, 8'd3, 8'd1);
    wait_done(300, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL repeat_timeout: got no DONE, expected DONE"); end
    checks++;
    if (out_cnt !== 12) begin errors++; $display("FAIL repeat_count: got %0d words, expected 12", out_cnt); end
    checks++;
    if (restore_cnt !== 2) begin errors++; $display("FAIL repeat_restores: got %0d, expected 2", restore_cnt); end
    checks++;
    if (done_cyc - last_out_cyc !== 1) begin
      errors++;
      $display("FAIL repeat_done_lat: got %0d cycles after last word, expected 1", done_cyc - last_out_cyc);
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL repeat_left: got %0d missing words, expected 0", exp_q.size()); end
    @(negedge CLK);
    #3;
    checks++;
    if ({bi.DONE, bi.CFG_READY, bi.BUSY} !== 3'b010) begin
      errors++;
      $display("FAIL repeat_after: got done,rdy,busy=%b, expected 010", {bi.DONE, bi.CFG_READY, bi.BUSY});
    end
  endtask

  task automatic test_multi_tile;
    bit ok;
    load_job(3, 2, 2, 8'hB0);
    send_cfg(3'd3, 8'd2, 8'd2);
    wait_done(300, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL multi_timeout: got no DONE, expected DONE"); end
    checks++;
    if (out_cnt !== 12) begin errors++; $display("FAIL multi_count: got %0d words, expected 12", out_cnt); end
    checks++;
    if (push_cnt !== 6) begin errors++; $display("FAIL multi_pushes: got %0d, expected 6", push_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL multi_left: got %0d missing words, expected 0", exp_q.size()); end
  endtask

  task automatic test_full;
    bit ok;
    load_job(4, 2, 2, 8'hD0);
    src_q.push_back(8'hFF);
    watch_push = 4;
    send_cfg(3'd4, 8'd2, 8'd2);
    wait_done(400, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL full_timeout: got no DONE, expected DONE"); end
    checks++;
    if (out_cnt !== 16) begin errors++; $display("FAIL full_count: got %0d words, expected 16", out_cnt); end
    checks++;
    if (!(full_cyc > 0)) begin errors++; $display("FAIL full_seen: got %0d full cycles, expected >0", full_cyc); end
    checks++;
    if (pops_at_watch !== 8) begin
      errors++;
      $display("FAIL full_tile1_entry: got %0d pops before first tile-1 push, expected 8", pops_at_watch);
    end
    checks++;
    if (push_cnt !== 8) begin errors++; $display("FAIL full_pushes: got %0d, expected 8", push_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL full_left: got %0d missing words, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    bit ok;
    or_mode = 1;
    load_job(3, 2, 1, 8'h60);
    send_cfg(3'd3, 8'd2, 8'd1);
    wait_done(400, ok);
    or_mode = 0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got no DONE, expected DONE"); end
    checks++;
    if (out_cnt !== 6) begin errors++; $display("FAIL bp_count: got %0d words, expected 6", out_cnt); end
    checks++;
    if (pop_cnt !== 6) begin errors++; $display("FAIL bp_pops: got %0d, expected 6", pop_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_left: got %0d missing words, expected 0", exp_q.size()); end
  endtask

  task automatic test_illegal;
    logic [AW:0]   tl_t [4] = '{3'd0, 3'd2, 3'd5, 3'd2};
    logic [CW-1:0] rp_t [4] = '{8'd1, 8'd0, 8'd1, 8'd1};
    logic [CW-1:0] nt_t [4] = '{8'd1, 8'd1, 8'd1, 8'd0};
    for (int unsigned i = 0; i < 4; i++) begin
      send_cfg(tl_t[i], rp_t[i], nt_t[i]);
      #1;
      checks++;
      if ({bi.ERR, bi.BUSY, bi.CFG_READY} !== 3'b101) begin
        errors++;
        $display("FAIL illegal_%0d: got err,busy,rdy=%b, expected 101", i, {bi.ERR, bi.BUSY, bi.CFG_READY});
      end
      @(negedge CLK);
      #1;
      checks++;
      if ({bi.ERR, bi.BUSY, bi.CFG_READY} !== 3'b001) begin
        errors++;
        $display("FAIL illegal_%0d_after: got err,busy,rdy=%b, expected 001", i, {bi.ERR, bi.BUSY, bi.CFG_READY});
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    load_job(4, 3, 1, 8'h70);
    send_cfg(3'd4, 8'd3, 8'd1);
    for (int unsigned n = 0; n < 200 && out_cnt < 6; n++) begin
      @(negedge CLK);
      #3;
    end
    checks++;
    if (out_cnt !== 6) begin errors++; $display("FAIL rst_mid_reach: got %0d words, expected 6", out_cnt); end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if ({bi.BUSY, bi.CFG_READY, bi.OUT_VALID, bi.DONE, bi.BUF_POP, bi.BUF_PUSH} !== 6'b010000) begin
      errors++;
      $display("FAIL rst_mid_state: got busy,rdy,ov,done,pop,push=%b, expected 010000",
               {bi.BUSY, bi.CFG_READY, bi.OUT_VALID, bi.DONE, bi.BUF_POP, bi.BUF_PUSH});
    end
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.delete();
    src_q.delete();
    repeat (4) @(negedge CLK);
    #3;
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid_done: got %0d DONE pulses, expected 0", done_cnt); end
    load_job(2, 2, 1, 8'h80);
    send_cfg(3'd2, 8'd2, 8'd1);
    wait_done(200, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rst_fresh_timeout: got no DONE, expected DONE"); end
    checks++;
    if (out_cnt !== 4) begin errors++; $display("FAIL rst_fresh_count: got %0d words, expected 4", out_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_fresh_left: got %0d missing words, expected 0", exp_q.size()); end
  endtask

  initial begin
    RESET            = 1'b1;
    bi.CFG_VALID     = 1'b0;
    bi.CFG_TILE_LEN  = '0;
    bi.CFG_REPEAT    = '0;
    bi.CFG_NUM_TILES = '0;
    test_reset();
    test_repeat();
    test_multi_tile();
    test_full();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
